// File: rtl/dshot_output.sv
// DShot frame transmitter: builds a 16-bit frame (value, telemetry, CRC) on handshake
// and serialises it MSB-first as pulse-width-coded bits, followed by a low idle gap.
module dshot_output #(
   parameter int BIT_CYCLES = 27,
   parameter int T1H_CYCLES = 20,
   parameter int T0H_CYCLES = 10,
   parameter int GAP_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [10:0] speed,
   input  logic [5:0]  command,
   input  logic        is_command,
   input  logic        telemetry_req,
   input  logic        send_valid,
   output logic        send_ready,
   output logic        dshot_out,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] sent_frame
);

   localparam int CNT_MAX = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] HI1_LAST = CW'(T1H_CYCLES - 1);
   localparam logic [CW-1:0] HI0_LAST = CW'(T0H_CYCLES - 1);
   localparam logic [CW-1:0] LO1_LAST = CW'(BIT_CYCLES - T1H_CYCLES - 1);
   localparam logic [CW-1:0] LO0_LAST = CW'(BIT_CYCLES - T0H_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

   generate
      if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES && GAP_CYCLES >= 1)) begin : gBadParams
         $error("dshot_output: illegal bit timing parameters");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

   state_t        state, stateNext;
   logic [CW-1:0] phaseCnt, phaseCntNext;
   logic [3:0]    bitIdx, bitIdxNext;
   logic [15:0]   shiftReg, shiftNext, sentNext;
   logic          outNext;

   logic [10:0]   clampedSpeed, frameValue;
   logic [11:0]   frameWord;
   logic [15:0]   newFrame;
   logic [CW-1:0] hiLast, loLast;

   // The clamp keeps speed+48 inside 11 bits, so the add can never wrap.
   assign clampedSpeed = (speed > 11'd1999) ? 11'd1999 : speed;
   assign frameValue   = is_command ? {5'b0, command} : clampedSpeed + 11'd48;
   assign frameWord    = {frameValue, telemetry_req};
   assign newFrame     = {frameWord, frameWord[3:0] ^ frameWord[7:4] ^ frameWord[11:8]};

   assign hiLast     = shiftReg[15] ? HI1_LAST : HI0_LAST;
   assign loLast     = shiftReg[15] ? LO1_LAST : LO0_LAST;
   assign send_ready = (state == IDLE);
   assign busy       = (state != IDLE);

   // State, phase counter and frame registers; the output pin is registered here too.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         phaseCnt   <= '0;
         bitIdx     <= '0;
         shiftReg   <= '0;
         sent_frame <= '0;
         dshot_out  <= 1'b0;
      end else begin
         state      <= stateNext;
         phaseCnt   <= phaseCntNext;
         bitIdx     <= bitIdxNext;
         shiftReg   <= shiftNext;
         sent_frame <= sentNext;
         dshot_out  <= outNext;
      end
   end

   // Next-state logic; the current bit is always shiftReg[15] until the next HIGH begins.
   always_comb begin
      stateNext    = state;
      phaseCntNext = phaseCnt + CW'(1);
      bitIdxNext   = bitIdx;
      shiftNext    = shiftReg;
      sentNext     = sent_frame;
      outNext      = dshot_out;
      frame_done   = 1'b0;
      case (state)
         IDLE: begin
            phaseCntNext = '0;
            if (send_valid) begin
               stateNext  = HIGH;
               shiftNext  = newFrame;
               sentNext   = newFrame;
               bitIdxNext = '0;
               outNext    = 1'b1;
            end
         end
         HIGH: begin
            if (phaseCnt == hiLast) begin
               stateNext    = LOW;
               phaseCntNext = '0;
               outNext      = 1'b0;
            end
         end
         LOW: begin
            if (phaseCnt == loLast) begin
               phaseCntNext = '0;
               if (bitIdx == 4'd15) begin
                  stateNext = GAP;
               end else begin
                  stateNext  = HIGH;
                  bitIdxNext = bitIdx + 4'd1;
                  shiftNext  = {shiftReg[14:0], 1'b0};
                  outNext    = 1'b1;
               end
            end
         end
         GAP: begin
            if (phaseCnt == GAP_LAST) begin
               stateNext    = IDLE;
               phaseCntNext = '0;
               frame_done   = 1'b1;
            end
         end
         default: begin
            stateNext = IDLE;
            outNext   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_dshot_output.sv
// Self-checking bench for dshot_output: a waveform-queue model checked every cycle,
// an in-bench pulse-width decoder for loopback, and directed literal frame checks.
module tb_dshot_output;

   logic        clk;
   logic        reset_n;
   logic [10:0] speed;
   logic [5:0]  command;
   logic        is_command;
   logic        telemetry_req;
   logic        send_valid;
   logic        send_ready;
   logic        dshot_out;
   logic        busy;
   logic        frame_done;
   logic [15:0] sent_frame;

   int assertCount = 0;
   int failCount   = 0;

   dshot_output dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .speed        (speed),
      .command      (command),
      .is_command   (is_command),
      .telemetry_req(telemetry_req),
      .send_valid   (send_valid),
      .send_ready   (send_ready),
      .dshot_out    (dshot_out),
      .busy         (busy),
      .frame_done   (frame_done),
      .sent_frame   (sent_frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // CRC is the XOR of the three nibbles of the 12-bit value+telemetry word.
   function automatic logic [3:0] crcOf(input logic [11:0] w);
      logic [3:0] c;
      c = 4'h0;
      for (int n = 0; n < 3; n++) c = c ^ w[n*4 +: 4];
      return c;
   endfunction

   function automatic logic [15:0] buildFrame(input logic cmd, input logic [10:0] spd,
                                              input logic [5:0] cmdv, input logic tel);
      int         v;
      logic [11:0] w;
      if (cmd) v = int'(cmdv);
      else     v = ((int'(spd) > 1999) ? 1999 : int'(spd)) + 48;
      w = {v[10:0], tel};
      return {w, crcOf(w)};
   endfunction

   // Model: on accept, the whole frame's expected pin levels are queued, one per cycle.
   logic        waveQ[$];
   logic        expOut, expBusy, expDone, expReady;
   logic [15:0] expSent;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         waveQ.delete();
         expOut   = 1'b0;
         expBusy  = 1'b0;
         expDone  = 1'b0;
         expReady = 1'b1;
         expSent  = 16'h0000;
      end else begin
         if (!expBusy && send_valid) begin
            expSent = buildFrame(is_command, speed, command, telemetry_req);
            for (int b = 15; b >= 0; b--) begin
               for (int c = 0; c < 27; c++) waveQ.push_back(c < (expSent[b] ? 20 : 10));
            end
            for (int g = 0; g < 32; g++) waveQ.push_back(1'b0);
         end
         if (waveQ.size() > 0) begin
            expOut  = waveQ.pop_front();
            expBusy = 1'b1;
            expDone = (waveQ.size() == 0);
         end else begin
            expOut  = 1'b0;
            expBusy = 1'b0;
            expDone = 1'b0;
         end
         expReady = !expBusy;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Per-cycle compare against the model, plus a pulse-width decoder of the pin.
   task automatic compareLoop();
      int          hiCnt = 0;
      int          nBits = 0;
      logic [15:0] decWord = 16'h0000;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            hiCnt = 0;
            nBits = 0;
         end else begin
            checkOutput("dshot_out", {31'b0, dshot_out}, {31'b0, expOut});
            checkOutput("busy", {31'b0, busy}, {31'b0, expBusy});
            checkOutput("send_ready", {31'b0, send_ready}, {31'b0, expReady});
            checkOutput("frame_done", {31'b0, frame_done}, {31'b0, expDone});
            checkOutput("sent_frame", {16'b0, sent_frame}, {16'b0, expSent});
            if (dshot_out) begin
               hiCnt++;
            end else if (hiCnt > 0) begin
               decWord = {decWord[14:0], (hiCnt > 15)};
               nBits++;
               hiCnt = 0;
            end
            if (frame_done) begin
               checkOutput("loop_bits", nBits, 16);
               checkOutput("loop_frame", {16'b0, decWord}, {16'b0, expSent});
               checkOutput("loop_crc", {28'b0, decWord[3:0]}, {28'b0, crcOf(decWord[15:4])});
               nBits = 0;
            end
         end
      end
   endtask

   task automatic waitDone(output int cycles);
      cycles = 0;
      while (!frame_done && cycles < 600) begin
         @(posedge clk); #1;
         cycles++;
      end
      checkOutput("frame_done_seen", {31'b0, frame_done}, 32'd1);
   endtask

   task automatic applyStimulus(input logic cmd, input logic [10:0] spd, input logic [5:0] cmdv,
                                input logic tel, input logic [15:0] expFrame);
      int waitCycles;
      @(posedge clk); #1;
      is_command    = cmd;
      speed         = spd;
      command       = cmdv;
      telemetry_req = tel;
      send_valid    = 1'b1;
      waitCycles    = 0;
      while (!send_ready && waitCycles < 1000) begin
         @(posedge clk); #1;
         waitCycles++;
      end
      checkOutput("accept_ready", {31'b0, send_ready}, 32'd1);
      @(posedge clk); #1;
      send_valid = 1'b0;
      checkOutput("frame_word", {16'b0, sent_frame}, {16'b0, expFrame});
      checkOutput("first_high", {31'b0, dshot_out}, 32'd1);
      waitDone(waitCycles);
      checkOutput("done_latency", waitCycles + 1, 464);
      @(posedge clk); #1;
   endtask

   task automatic backToBack();
      int          speeds[3] = '{100, 500, 1000};
      logic [15:0] frames[3] = '{16'h128B, 16'h4488, 16'h830B};
      int          cycles;
      @(posedge clk); #1;
      is_command    = 1'b0;
      telemetry_req = 1'b0;
      speed         = 11'(speeds[0]);
      send_valid    = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         checkOutput("b2b_frame", {16'b0, sent_frame}, {16'b0, frames[k]});
         repeat (200) @(posedge clk);
         #1;
         if (k < 2) speed = 11'(speeds[k+1]);
         waitDone(cycles);
         if (k == 2) begin
            send_valid = 1'b0;
         end else begin
            @(posedge clk); #1;
            checkOutput("b2b_idle_ready", {31'b0, send_ready}, 32'd1);
            checkOutput("b2b_idle_low", {31'b0, dshot_out}, 32'd0);
            @(posedge clk); #1;
            checkOutput("b2b_restart", {31'b0, dshot_out}, 32'd1);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic resetMidFrame();
      @(posedge clk); #1;
      is_command    = 1'b0;
      speed         = 11'd0;
      telemetry_req = 1'b0;
      send_valid    = 1'b1;
      @(posedge clk); #1;
      send_valid = 1'b0;
      repeat (195) @(posedge clk);
      #1;
      checkOutput("pre_reset_high", {31'b0, dshot_out}, 32'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("reset_drop", {31'b0, dshot_out}, 32'd0);
      checkOutput("reset_busy", {31'b0, busy}, 32'd0);
      repeat (4) begin
         @(posedge clk); #1;
         checkOutput("reset_no_done", {31'b0, frame_done}, 32'd0);
      end
      reset_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("release_ready", {31'b0, send_ready}, 32'd1);
      checkOutput("release_frame", {16'b0, sent_frame}, 32'd0);
   endtask

   initial begin
      reset_n       = 1'b0;
      speed         = 11'd0;
      command       = 6'd0;
      is_command    = 1'b0;
      telemetry_req = 1'b0;
      send_valid    = 1'b0;
      fork
         compareLoop();
         begin
            repeat (3) @(posedge clk);
            #1;
            checkOutput("rst_dshot_out", {31'b0, dshot_out}, 32'd0);
            checkOutput("rst_busy", {31'b0, busy}, 32'd0);
            checkOutput("rst_frame_done", {31'b0, frame_done}, 32'd0);
            checkOutput("rst_sent_frame", {16'b0, sent_frame}, 32'd0);
            reset_n = 1'b1;
            @(posedge clk); #1;
            checkOutput("rst_send_ready", {31'b0, send_ready}, 32'd1);

            applyStimulus(1'b0, 11'd0,    6'd0,  1'b0, 16'h0606);
            applyStimulus(1'b0, 11'd1999, 6'd0,  1'b1, 16'hFFFF);
            applyStimulus(1'b0, 11'd2047, 6'd0,  1'b1, 16'hFFFF);
            applyStimulus(1'b1, 11'd0,    6'd0,  1'b0, 16'h0000);
            applyStimulus(1'b1, 11'd0,    6'd10, 1'b1, 16'h0154);
            backToBack();
            resetMidFrame();
            applyStimulus(1'b0, 11'd100,  6'd0,  1'b0, 16'h128B);
            for (int r = 0; r < 20; r++) begin
               logic        rCmd, rTel;
               logic [10:0] rSpd;
               logic [5:0]  rCmdv;
               rCmd  = 1'($urandom_range(0, 1));
               rTel  = 1'($urandom_range(0, 1));
               rSpd  = 11'($urandom_range(0, 2047));
               rCmdv = 6'($urandom_range(0, 47));
               applyStimulus(rCmd, rSpd, rCmdv, rTel, buildFrame(rCmd, rSpd, rCmdv, rTel));
            end
         end
      join_any
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/dshot_output.md
Name: dshot_output

Overview:
DShot frame transmitter, the transmit-side counterpart of the DShot input decoder. It accepts a throttle value or a special command over a valid/ready handshake, builds the 16-bit frame (11-bit value, telemetry bit, 4-bit CRC), and serialises it MSB-first as pulse-width-coded bits on a single registered output pin. It sits between the speed/command logic and the ESC-side pin, for driving downstream ESCs or looping back into the input decoder for test.

Parameters:
BIT_CYCLES, 27, clk cycles per bit period (DShot600 at 16 MHz ≈ 26.67, rounded up)
T1H_CYCLES, 20, high time of a '1' bit in clk cycles (~75%)
T0H_CYCLES, 10, high time of a '0' bit in clk cycles (~37.5%)
GAP_CYCLES, 32, minimum low idle time after a frame before the next can start

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
speed  input  11  throttle 0..1999; values >1999 clamp to 1999
command  input  6  special command 0..47
is_command  input  1  1: send command; 0: send speed
telemetry_req  input  1  telemetry bit to place in the frame
send_valid  input  1  request to transmit; fields sampled on handshake
send_ready  output  1  high only in IDLE; frame accepted when send_valid && send_ready
dshot_out  output  1  registered serial DShot output, idle low
busy  output  1  high from accept through end of GAP
frame_done  output  1  one-cycle pulse when GAP completes
sent_frame  output  16  last accepted frame word, held until next accept

Behaviour:
- Reset (async assert, sync release): state IDLE, dshot_out=0, busy=0, frame_done=0, send_ready=1 after release, sent_frame=16'h0000, counters 0.
- Frame build at accept: value = is_command ? {5'b0,command} : min(speed,1999)+48 (11 bits). command values ≥48 are sent as-is, unchecked. w = {value, telemetry_req} (12 bits). crc = (w ^ w>>4 ^ w>>8)[3:0]. frame = {w, crc}. The frame is latched into the shift register and sent_frame in the accept cycle.
- States: IDLE -> HIGH -> LOW -> (HIGH for next bit | GAP after bit 15) -> IDLE.
- Accept in cycle N. dshot_out=1 from cycle N+1.
- HIGH lasts T1H_CYCLES or T0H_CYCLES according to the current bit. LOW lasts the remainder of BIT_CYCLES.
- Each bit is exactly BIT_CYCLES cycles. Bits are sent MSB first. Bit counter runs 0..15.
- After bit 15's LOW phase, GAP holds dshot_out=0 for GAP_CYCLES.
- frame_done pulses in the last GAP cycle. send_ready rises the next cycle.
- Total busy = 16*BIT_CYCLES + GAP_CYCLES cycles per frame.
- send_valid held high gives back-to-back frames. Next accept occurs in the first IDLE cycle, so the next rising edge of dshot_out comes 1 cycle after that.
- send_valid and all fields are ignored while busy. Fields are not re-sampled mid-frame.
- reset_n asserted mid-frame: dshot_out drops to 0 immediately, frame abandoned, no frame_done.
- Parameter legality, checked by elaboration assertion: 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES, GAP_CYCLES ≥ 1.
- Arithmetic: the clamp compare is done on 11 bits. speed+48 is computed in 11 bits, with max 2047 and no overflow after clamp.

Test Plan:
- Speed 0, telem 0, is_command 0 -> sent_frame=16'h0606. Waveform: bits 0000011000000110, '1' high 20/low 7, '0' high 10/low 17; frame_done at cycle 16*27+32 after accept.
- Speed 1999, telem 1 -> sent_frame=16'hFFFF, all sixteen pulses 20 cycles high. Repeat with speed 2047 -> clamped, identical 16'hFFFF.
- is_command 1, command 0, telem 0 -> 16'h0000, sixteen 10-cycle pulses. Command 10, telem 1 -> 16'h0154.
- send_valid held high for 3 frames with changing speed mid-frame -> each frame reflects fields at its accept cycle only. Gaps are exactly 32 low cycles plus 1 IDLE cycle. send_ready is high one cycle per frame.
- reset_n pulsed low during bit 7 -> dshot_out 0 the same cycle, no frame_done, send_ready=1 after release. A new frame sends correctly.
- Loopback: dshot_output drives the DShot input decoder. For 20 random speed/command/telem combos, the decoder reports CRC valid and matching speed/command/telemetry.
